// File: rtl/hub75_bcm_scan_ctrl.sv
// HUB75 panel scan controller with binary-coded modulation: shifts one bit plane of a
// row pair, latches it, then holds NOE low for BASE_ON<<plane cycles.
module hub75_bcm_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 32,
  parameter int BPC       = 4,
  parameter int CLK_DIV   = 2,
  parameter int BASE_ON   = 8,
  localparam int ROW_W    = $clog2(SCAN_ROWS),
  localparam int COL_W    = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [ROW_W-1:0]   rd_row,
  output logic [COL_W-1:0]   rd_col,
  input  logic [3*BPC-1:0]   pix_top,
  input  logic [3*BPC-1:0]   pix_bot,
  output logic               LP_CLK,
  output logic               LATCH,
  output logic               NOE,
  output logic [ROW_W-1:0]   ROW,
  output logic [2:0]         RGB0,
  output logic [2:0]         RGB1,
  output logic               frame_done,
  output logic [2:0]         dbg_state
);

  localparam int PL_W   = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int PH_W   = $clog2(2 * CLK_DIV);
  localparam int ON_MAX = BASE_ON << (BPC - 1);
  localparam int ON_W   = $clog2(ON_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_BLANK = 3'd2,
    ST_LATCH = 3'd3,
    ST_DISP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [PL_W-1:0]   plane_q;
  logic [ON_W-1:0]   on_q;
  logic [ON_W-1:0]   on_last;
  logic              stop_q;
  logic              slot_end, latch_end, disp_end, go_idle;

  // Frame-buffer read: the address is held for a whole slot; data is valid the cycle
  // after the address (slot cycle 1) and is captured then, ahead of the LP_CLK rise.
  assign rd_row = row_q;
  assign rd_col = col_q;

  assign on_last   = ON_W'((BASE_ON << plane_q) - 1);
  assign slot_end  = (ph_q == PH_W'(2 * CLK_DIV - 1));
  assign latch_end = (ph_q == PH_W'(CLK_DIV - 1));
  assign disp_end  = (on_q == on_last);
  assign go_idle   = stop_q || !en;

  function automatic logic [2:0] plane_bits(input logic [3*BPC-1:0] px,
                                            input logic [PL_W-1:0]  p);
    logic [BPC-1:0] r, g, b;
    r = px[3*BPC-1 -: BPC] >> p;
    g = px[2*BPC-1 -: BPC] >> p;
    b = px[BPC-1:0] >> p;
    return {r[0], g[0], b[0]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = ST_SHIFT;
      ST_SHIFT: if (slot_end && col_q == COL_W'(COLS - 1)) state_d = ST_BLANK;
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: if (latch_end) state_d = ST_DISP;
      ST_DISP:  if (disp_end) state_d = go_idle ? ST_IDLE : ST_SHIFT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Panel strobes decode straight from the state register, so reset forces NOE high at once.
  always_comb begin
    NOE       = (state_q != ST_DISP);
    LATCH     = (state_q == ST_LATCH);
    LP_CLK    = (state_q == ST_SHIFT) && (ph_q >= PH_W'(CLK_DIV));
    dbg_state = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      on_q       <= '0;
      stop_q     <= 1'b0;
      ROW        <= '0;
      RGB0       <= '0;
      RGB1       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          ph_q    <= '0;
          col_q   <= '0;
          row_q   <= '0;
          plane_q <= '0;
          on_q    <= '0;
          stop_q  <= 1'b0;
        end
        ST_SHIFT: begin
          if (!en) stop_q <= 1'b1;
          if (ph_q == PH_W'(1)) begin
            RGB0 <= plane_bits(pix_top, plane_q);
            RGB1 <= plane_bits(pix_bot, plane_q);
          end
          if (slot_end) begin
            ph_q  <= '0;
            col_q <= col_q + 1'b1;
          end else begin
            ph_q <= ph_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (!en) stop_q <= 1'b1;
          ROW  <= row_q;
          ph_q <= '0;
        end
        ST_LATCH: begin
          if (!en) stop_q <= 1'b1;
          ph_q <= latch_end ? '0 : ph_q + 1'b1;
        end
        ST_DISP: begin
          if (disp_end) begin
            on_q <= '0;
            if (plane_q == PL_W'(BPC - 1)) begin
              plane_q <= '0;
              row_q   <= row_q + 1'b1;
              if (row_q == ROW_W'(SCAN_ROWS - 1)) frame_done <= 1'b1;
            end else begin
              plane_q <= plane_q + 1'b1;
            end
            if (go_idle) begin
              row_q   <= '0;
              plane_q <= '0;
            end
          end else begin
            on_q <= on_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scan_ctrl.sv
// Directed bench for hub75_bcm_scan_ctrl on a 4x(2x2) panel with 2-bit colour;
// each bit-plane window is followed cycle by cycle and checked against hand values.
module tb_hub75_bcm_scan_ctrl;

  localparam int COLS = 4, SCAN_ROWS = 2, BPC = 2, CLK_DIV = 2, BASE_ON = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic       rd_row;
  logic [1:0] rd_col;
  logic [5:0] pix_top = '0;
  logic [5:0] pix_bot = '0;
  logic       LP_CLK, LATCH, NOE, ROW, frame_done;
  logic [2:0] RGB0, RGB1, dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int mode  = 0;

  hub75_bcm_scan_ctrl #(
    .COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .BPC(BPC), .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rd_row(rd_row), .rd_col(rd_col),
    .pix_top(pix_top), .pix_bot(pix_bot), .LP_CLK(LP_CLK), .LATCH(LATCH),
    .NOE(NOE), .ROW(ROW), .RGB0(RGB0), .RGB1(RGB1), .frame_done(frame_done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Frame buffer content per test mode ({R,G,B}, 2 bits each).
  function automatic logic [5:0] fb_pix(input int m, input bit bot, input logic r, input logic [1:0] c);
    case (m)
      0:       return bot ? 6'b00_00_00 : 6'b11_00_00;
      1:       return bot ? 6'b00_00_00 : 6'b01_00_00;
      default: return bot ? {2'b10, c[0], 1'b0, r, 1'b0} : {1'b0, c[1], 1'b0, c[0], 2'b01};
    endcase
  endfunction

  // One-cycle read latency memory model.
  always @(posedge clk) begin
    pix_top <= fb_pix(mode, 1'b0, rd_row, rd_col);
    pix_bot <= fb_pix(mode, 1'b1, rd_row, rd_col);
  end

  // Hand-derived panel bits for plane p, column c, row r.
  function automatic logic [2:0] exp_rgb(input int m, input bit bot, input int p, input int c, input int r);
    logic [1:0] cc;
    logic [1:0] rr;
    cc = c[1:0];
    rr = r[1:0];
    case (m)
      0:       return bot ? 3'b000 : 3'b100;
      1:       return (bot || p == 1) ? 3'b000 : 3'b100;
      default: begin
        if (!bot) return (p == 0) ? {cc[1], cc[0], 1'b1} : 3'b000;
        else      return (p == 0) ? 3'b000 : {1'b1, cc[0], rr[0]};
      end
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called on a negedge; follows one plane from shift through display and returns on
  // the first negedge after NOE goes back high.
  task automatic observe_plane(input int row, input int plane, input bit stop);
    int rises = 0, latch_n = 0, noe_n = 0, cyc = 0, last_rise = 0, latch_at_noe = 0;
    bit prev_lp, seen_noe = 0, done = 0;
    logic [2:0] hold0 = '0, hold1 = '0;
    int exp_next;
    prev_lp = LP_CLK;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (LP_CLK && !prev_lp) begin
        if (rises > 0) check_eq("slot_len", cyc - last_rise, 2 * CLK_DIV);
        check_eq("rgb0_at_rise", RGB0, exp_rgb(mode, 0, plane, rises, row));
        check_eq("rgb1_at_rise", RGB1, exp_rgb(mode, 1, plane, rises, row));
        check_eq("rd_col_at_rise", rd_col, rises);
        check_eq("rd_row_at_rise", rd_row, row);
        last_rise = cyc;
        rises++;
        if (stop && rises == 2) en = 1'b0;
      end
      prev_lp = LP_CLK;
      if (LATCH) latch_n++;
      if (!NOE) begin
        if (!seen_noe) begin
          seen_noe = 1;
          latch_at_noe = latch_n;
          hold0 = RGB0;
          hold1 = RGB1;
          check_eq("row_in_display", ROW, row);
        end
        noe_n++;
      end else if (seen_noe) begin
        done = 1;
      end
    end
    check_eq("plane_timeout", done, 1);
    check_eq("rises_per_plane", rises, COLS);
    check_eq("latch_before_noe", latch_at_noe, CLK_DIV);
    check_eq("noe_low_cycles", noe_n, BASE_ON << plane);
    check_eq("rgb_stable_in_display", {RGB0, RGB1}, {hold0, hold1});
    exp_next = stop ? 0 : ((plane == BPC - 1) ? (row + 1) % SCAN_ROWS : row);
    check_eq("frame_done_after", frame_done, (!stop && row == 1 && plane == 1) ? 1 : 0);
    check_eq("rd_row_after", rd_row, exp_next);
    check_eq("state_after", dbg_state, stop ? 3'd0 : 3'd1);
  endtask

  initial begin
    int quiet;
    int waitn;
    // Reset held with en=1: outputs stay at reset values.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("reset_outputs",
               {NOE, LATCH, LP_CLK, ROW, RGB0, RGB1, frame_done, rd_row, rd_col, dbg_state},
               {1'b1, 16'b0});
    end
    rst = 1'b1;

    mode = 0;
    observe_plane(0, 0, 0);
    observe_plane(0, 1, 0);
    observe_plane(1, 0, 0);
    observe_plane(1, 1, 0);

    mode = 1;
    observe_plane(0, 0, 0);
    observe_plane(0, 1, 0);

    mode = 2;
    observe_plane(1, 0, 0);
    observe_plane(1, 1, 0);
    observe_plane(0, 0, 0);
    observe_plane(0, 1, 0);

    // Drop en in the second slot: plane finishes, then the block parks in IDLE.
    observe_plane(1, 0, 1);
    quiet = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (LP_CLK || !NOE || LATCH) quiet++;
    end
    check_eq("idle_quiet", quiet, 0);
    check_eq("idle_state", dbg_state, 3'd0);
    en = 1'b1;
    observe_plane(0, 0, 0);

    // Reset in the middle of the plane-1 display window.
    waitn = 0;
    while (NOE && waitn < 100) begin
      @(negedge clk);
      waitn++;
    end
    check_eq("display_reached", NOE, 0);
    @(negedge clk);
    @(negedge clk);
    check_eq("display_mid", NOE, 0);
    rst = 1'b0;
    #1;
    check_eq("async_noe", NOE, 1);
    check_eq("async_outputs",
             {NOE, LATCH, LP_CLK, ROW, RGB0, RGB1, frame_done, rd_row, rd_col, dbg_state},
             {1'b1, 16'b0});
    @(negedge clk);
    check_eq("reset_hold",
             {NOE, LATCH, LP_CLK, ROW, RGB0, RGB1, frame_done, rd_row, rd_col, dbg_state},
             {1'b1, 16'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_scan_ctrl.md
Name: hub75_bcm_scan_ctrl

Overview:
- Parametrised successor to the 1-bit LED matrix driver in the temperature display top.
- Drives a HUB75 panel (LP_CLK, LATCH, NOE, ROW, RGB0, RGB1) with binary-coded modulation (BCM) for BPC bits per colour channel.
- Fetches pixels from an external frame buffer with a 1-cycle read latency.
- Sits between the pixel generator/frame buffer and the panel pins; replaces the fixed-size single-bit scan FSM.

Parameters:
- COLS, 64: pixels shifted per row (power of 2).
- SCAN_ROWS, 32: scanned row pairs (power of 2); ROW_W = clog2(SCAN_ROWS), COL_W = clog2(COLS).
- BPC, 4: bits per colour channel (1..8).
- CLK_DIV, 2: clk cycles per LP_CLK half-period (>=2).
- BASE_ON, 8: NOE-low cycles for bit plane 0; plane b gets BASE_ON<<b.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- rd_row  out  ROW_W  frame-buffer row address (top half row).
- rd_col  out  COL_W  frame-buffer column address.
- pix_top  in  3*BPC  {R,G,B} for row rd_row; valid the cycle after the address.
- pix_bot  in  3*BPC  {R,G,B} for row rd_row+SCAN_ROWS; same timing.
- LP_CLK  out  1  panel shift clock.
- LATCH  out  1  panel latch.
- NOE  out  1  panel output enable, active-low.
- ROW  out  ROW_W  panel row select.
- RGB0  out  3  top-half bits {R,G,B}.
- RGB1  out  3  bottom-half bits {R,G,B}.
- frame_done  out  1  one-cycle pulse after the last plane of the last row.

Behaviour:
- Reset (asynchronous, rst=0): NOE=1, LATCH=0, LP_CLK=0, ROW=0, RGB0=RGB1=0, rd_row=0, rd_col=0, frame_done=0, row=0, plane=0, column=0, FSM=IDLE.
- FSM states: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE: NOE=1. When en=1, go to SHIFT at row=0, plane=0.
- SHIFT: each column slot lasts 2*CLK_DIV cycles.
  - Slot cycle 0: rd_col=c, rd_row=row, LP_CLK=0.
  - Slot cycle 1: RGB0/RGB1 register bit `plane` of each channel of pix_top/pix_bot.
  - Slot cycles CLK_DIV..2*CLK_DIV-1: LP_CLK=1.
  - After slot COLS-1 completes, LP_CLK=0 and go to BLANK.
- BLANK: one cycle, NOE=1; ROW<=row.
- LATCH: LATCH=1 for CLK_DIV cycles, then go to DISPLAY.
- DISPLAY: NOE=0 for exactly BASE_ON<<plane cycles, then NOE=1.
  - If plane<BPC-1: plane++ and return to SHIFT.
  - Otherwise plane=0 and row++.
  - On row wrap (SCAN_ROWS-1 to 0): frame_done=1 for one cycle.
  - Continue in SHIFT if en=1, else go to IDLE.
- NOE is 1 in every state except DISPLAY.
- No overlap between shifting and display: RGB only changes while NOE=1.
- en sampled low during SHIFT, BLANK or LATCH: the current plane still completes (including DISPLAY), then the block goes to IDLE.
- Resume after IDLE always restarts at row 0, plane 0.
- Width rules:
  - On-time counter is COL_W-independent and sized for BASE_ON<<(BPC-1).
  - Column counter wraps at COLS; no overflow states.
- Reset mid-operation: all outputs go to their reset values immediately; NOE goes high asynchronously.

Test Plan:
Bench parameters: COLS=4, SCAN_ROWS=2, BPC=2, CLK_DIV=2, BASE_ON=3.
- Reset, rst=0 with en=1 -> NOE=1, LATCH=0, LP_CLK=0, ROW=0, RGB0=RGB1=000, frame_done=0 throughout.
- pix_top={R=2'b11,G=0,B=0}, pix_bot=0, en=1 -> RGB0=100 and RGB1=000 at every LP_CLK rise; 4 rises per plane; each slot is 4 clk cycles.
- pix_top R=2'b01 -> plane 0: RGB0=100 at all 4 rises; plane 1: RGB0=000; NOE low for 3 cycles then 6 cycles; LATCH high for 2 cycles before each NOE-low window.
- Full frame -> ROW sequence 0,0,1,1 across plane windows; frame_done pulses once after the row 1 plane 1 window; the next SHIFT has rd_row=0.
- Read latency: frame-buffer model returns pix_top=col index pattern one cycle after rd_col -> RGB0 at rises follows column order 0..3 with no skew.
- en=0 during the second SHIFT slot -> that plane's latch and 3-cycle display complete, then IDLE with NOE=1; en=1 again -> restarts at rd_row=0, plane 0.
- rst=0 asserted in the middle of a DISPLAY window -> NOE=1 in the same cycle; all outputs at reset values.
